// File: rtl/game_flow_ctl_pkg.sv
// Shared constants for the Memory Game screen flow: screen encodings, card counts, frame defaults.
package game_flow_ctl_pkg;

    typedef enum logic [1:0] {
        GF_MENU    = 2'd0,
        GF_OPTIONS = 2'd1,
        GF_PLAY    = 2'd2,
        GF_RESULT  = 2'd3
    } gf_state_e;

    localparam int CARD_MAX_NUM_SIZE = 6;
    localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_EASY   = 6'd8;
    localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_NORMAL = 6'd16;
    localparam logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_HARD   = 6'd24;

    localparam int RESULT_FRAMES_DEF = 180;
    localparam int IDLE_FRAMES_DEF   = 1800;
    localparam int TIMER_W_DEF       = 11;

endpackage

// File: rtl/game_flow_ctl_click_mask.sv
// Suppresses a mouse button held across a screen change until it is released once;
// also provides a rising-edge strobe of the gated button and an any-edge strobe of the raw level.
module click_mask (
    input  logic clk,
    input  logic rst,
    input  logic mouse_left,
    input  logic set_mask,
    output logic mouse_left_gated,
    output logic gated_rise,
    output logic raw_edge
);

    logic mask_q, mask_d;
    logic gated_prev_q;
    logic raw_prev_q;

    assign mouse_left_gated = mouse_left & ~mask_q;
    assign gated_rise       = mouse_left_gated & ~gated_prev_q;
    assign raw_edge         = mouse_left ^ raw_prev_q;

    // A new screen always re-arms the mask, even if the button was already released.
    always_comb begin
        mask_d = mask_q;
        if (set_mask)
            mask_d = 1'b1;
        else if (!mouse_left)
            mask_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q       <= 1'b1;
            gated_prev_q <= 1'b0;
            raw_prev_q   <= 1'b0;
        end else begin
            mask_q       <= mask_d;
            gated_prev_q <= mouse_left_gated;
            raw_prev_q   <= mouse_left;
        end
    end

endmodule

// File: rtl/game_flow_ctl.sv
// Memory Game screen sequencer: one-hot screen enables, card-count latch, RESULT hold timer.
// Optional OPTIONS inactivity return to MENU is enabled by defining GAME_FLOW_IDLE_EN.
module game_flow_ctl
    import game_flow_ctl_pkg::*;
#(
    parameter int RESULT_FRAMES = RESULT_FRAMES_DEF,
    parameter int IDLE_FRAMES   = IDLE_FRAMES_DEF,
    parameter int TIMER_W       = TIMER_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic                         mouse_left,
    input  logic                         start_butt_pressed,
    input  logic                         options_butt_pressed,
    input  logic                         difficulty_butts_pressed,
    input  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards_in,
    input  logic                         game_won,
    output logic                         mouse_left_gated,
    output logic                         menu_en,
    output logic                         options_en,
    output logic                         game_en,
    output logic                         result_en,
    output logic                         game_start,
    output logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards
);

`ifdef GAME_FLOW_IDLE_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    localparam logic [TIMER_W-1:0] RESULT_LAST = TIMER_W'(RESULT_FRAMES - 1);
    localparam logic [TIMER_W-1:0] IDLE_LAST   = TIMER_W'(IDLE_FRAMES - 1);

    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    gf_state_e                    state_q, state_d;
    logic [TIMER_W-1:0]           timer_q, timer_d;
    logic                         menu_en_q, options_en_q, game_en_q, result_en_q;
    logic                         game_start_q;
    logic [CARD_MAX_NUM_SIZE-1:0] cards_q;
    logic                         transition;
    logic                         gated_rise;
    logic                         raw_edge;

    click_mask u_click_mask (
        .clk              (clk),
        .rst              (rst),
        .mouse_left       (mouse_left),
        .set_mask         (transition),
        .mouse_left_gated (mouse_left_gated),
        .gated_rise       (gated_rise),
        .raw_edge         (raw_edge)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            GF_MENU: begin
                if (start_butt_pressed)
                    state_d = GF_PLAY;
                else if (options_butt_pressed)
                    state_d = GF_OPTIONS;
            end
            GF_OPTIONS: begin
                if (difficulty_butts_pressed)
                    state_d = GF_MENU;
                else if (IDLE_EN && raw_edge)
                    timer_d = '0;
                else if (IDLE_EN && frame_tick) begin
                    if (timer_q == IDLE_LAST)
                        state_d = GF_MENU;
                    else
                        timer_d = sat_inc(timer_q);
                end
            end
            GF_PLAY: begin
                if (game_won)
                    state_d = GF_RESULT;
            end
            GF_RESULT: begin
                if (gated_rise)
                    state_d = GF_MENU;
                else if (frame_tick) begin
                    if (timer_q == RESULT_LAST)
                        state_d = GF_MENU;
                    else
                        timer_d = sat_inc(timer_q);
                end
            end
            default: state_d = GF_MENU;
        endcase
        // Entry clear has priority over any same-cycle frame tick.
        if (state_d != state_q)
            timer_d = '0;
    end

    assign transition = (state_d != state_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= GF_MENU;
            timer_q      <= '0;
            menu_en_q    <= 1'b1;
            options_en_q <= 1'b0;
            game_en_q    <= 1'b0;
            result_en_q  <= 1'b0;
            game_start_q <= 1'b0;
            cards_q      <= CARD_NUM_NORMAL;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            menu_en_q    <= (state_d == GF_MENU);
            options_en_q <= (state_d == GF_OPTIONS);
            game_en_q    <= (state_d == GF_PLAY);
            result_en_q  <= (state_d == GF_RESULT);
            game_start_q <= (state_q == GF_MENU) && (state_d == GF_PLAY);
            if ((state_q == GF_MENU) && (state_d == GF_PLAY))
                cards_q <= num_of_cards_in;
        end
    end

    assign menu_en      = menu_en_q;
    assign options_en   = options_en_q;
    assign game_en      = game_en_q;
    assign result_en    = result_en_q;
    assign game_start   = game_start_q;
    assign num_of_cards = cards_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Self-checking bench for game_flow_ctl: directed scenarios plus randomized traffic against a screen-level model.
module tb_game_flow_ctl;
    import game_flow_ctl_pkg::*;

    localparam int RF = 180;
    localparam int IF = 20;
`ifdef GAME_FLOW_IDLE_EN
    localparam bit IDLE = 1'b1;
`else
    localparam bit IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_tick = 1'b0, mouse_left = 1'b0;
    logic start_b = 1'b0, options_b = 1'b0, diff_b = 1'b0, won = 1'b0;
    logic [CARD_MAX_NUM_SIZE-1:0] cards_in = CARD_NUM_EASY;
    logic gated, menu_en, options_en, game_en, result_en, game_start;
    logic [CARD_MAX_NUM_SIZE-1:0] cards;

    int checks = 0;
    int passed = 0;

    game_flow_ctl #(.RESULT_FRAMES(RF), .IDLE_FRAMES(IF), .TIMER_W(11)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
        .start_butt_pressed(start_b), .options_butt_pressed(options_b),
        .difficulty_butts_pressed(diff_b), .num_of_cards_in(cards_in), .game_won(won),
        .mouse_left_gated(gated), .menu_en(menu_en), .options_en(options_en),
        .game_en(game_en), .result_en(result_en), .game_start(game_start),
        .num_of_cards(cards)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Screen-level model: screen 0=menu 1=options 2=play 3=result; frames counts ticks spent on the screen.
    int  m_scr, m_frames, m_nscr;
    bit  m_armed, m_prev_gated, m_prev_raw, m_start;
    bit  m_g, m_click, m_ev;
    logic [CARD_MAX_NUM_SIZE-1:0] m_cards;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_scr = 0; m_frames = 0; m_armed = 1; m_prev_gated = 0; m_prev_raw = 0;
            m_start = 0; m_cards = CARD_NUM_NORMAL;
        end else begin
            m_g     = mouse_left && !m_armed;
            m_click = m_g && !m_prev_gated;
            m_ev    = (mouse_left != m_prev_raw);
            m_nscr  = m_scr;
            if (m_scr == 0) m_nscr = start_b ? 2 : (options_b ? 1 : 0);
            else if (m_scr == 1) begin
                if (diff_b) m_nscr = 0;
                else if (IDLE && !m_ev && frame_tick && m_frames + 1 >= IF) m_nscr = 0;
            end
            else if (m_scr == 2) begin
                if (won) m_nscr = 3;
            end
            else if (m_click || (frame_tick && m_frames + 1 >= RF)) m_nscr = 0;
            m_start = (m_scr == 0 && m_nscr == 2);
            if (m_start) m_cards = cards_in;
            if (m_nscr != m_scr) begin
                m_frames = 0;
                m_armed  = 1;
            end else begin
                if (m_scr == 3 && frame_tick && m_frames < 2047) m_frames++;
                if (m_scr == 1 && IDLE) m_frames = m_ev ? 0 : m_frames + int'(frame_tick);
                if (!mouse_left) m_armed = 0;
            end
            m_prev_gated = m_g;
            m_prev_raw   = mouse_left;
            m_scr        = m_nscr;
        end
    end

    always @(negedge clk) begin
        chk("screen_enables", {menu_en, options_en, game_en, result_en},
            {m_scr == 0, m_scr == 1, m_scr == 2, m_scr == 3});
        chk("game_start", game_start, m_start);
        chk("num_of_cards", cards, m_cards);
        chk("mouse_left_gated", gated, mouse_left && !m_armed);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send_tick();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(2);
    endtask

    int n;

    initial begin
        mouse_left = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc();
        #1;
        chk("reset_menu_en", menu_en, 1);
        chk("reset_others", {options_en, game_en, result_en, game_start}, 0);
        chk("reset_cards", cards, 16);
        chk("reset_gated_masked", gated, 0);
        mouse_left = 1'b0; cyc(); mouse_left = 1'b1; #1;
        chk("gated_after_release", gated, 1);
        mouse_left = 1'b0;

        options_b = 1'b1; cyc(); options_b = 1'b0; #1;
        chk("enter_options", options_en, 1);
        cards_in = CARD_NUM_HARD;
        diff_b = 1'b1; cyc(); diff_b = 1'b0; #1;
        chk("back_to_menu", menu_en, 1);
        cyc();
        mouse_left = 1'b1;
        start_b = 1'b1; cyc(); start_b = 1'b0; #1;
        chk("enter_play", game_en, 1);
        chk("game_start_pulse", game_start, 1);
        chk("cards_hard", cards, 24);
        cyc(); #1;
        chk("game_start_one_cycle", game_start, 0);
        chk("held_click_masked", gated, 0);
        cyc(3);
        chk("held_click_still_masked", gated, 0);
        mouse_left = 1'b0; cyc(); mouse_left = 1'b1; #1;
        chk("fresh_click_passes", gated, 1);
        mouse_left = 1'b0;

        won = 1'b1; cyc(); won = 1'b0; #1;
        chk("enter_result", result_en, 1);
        n = 0;
        while (result_en && n < 300) begin send_tick(); n++; end
        chk("result_hold_ticks", n, 180);
        chk("auto_return_menu", menu_en, 1);

        cards_in = CARD_NUM_EASY;
        start_b = 1'b1; cyc(); start_b = 1'b0;
        chk("cards_easy", cards, 8);
        won = 1'b1; cyc(); won = 1'b0; cyc();
        n = 0;
        while (result_en && n < 300) begin
            if (n == 9) mouse_left = 1'b1;
            send_tick(); n++;
        end
        mouse_left = 1'b0;
        chk("click_return_tick", n, 10);
        chk("click_return_menu", menu_en, 1);

        cyc();
        start_b = 1'b1; options_b = 1'b1; cyc(); start_b = 1'b0; options_b = 1'b0; #1;
        chk("start_wins", {game_en, options_en}, 2);
        cyc(2);
        rst = 1'b0; #1;
        chk("async_reset_menu", {menu_en, game_en}, 2);
        chk("async_reset_cards", cards, 16);
        cyc(); rst = 1'b1; cyc();

        options_b = 1'b1; cyc(); options_b = 1'b0;
        n = 0;
        while (options_en && n < 40) begin send_tick(); n++; end
        chk("idle_return_ticks", n, IDLE ? 20 : 40);
        if (!options_en) begin options_b = 1'b1; cyc(); options_b = 1'b0; end
        repeat (15) send_tick();
        mouse_left = 1'b1; cyc(); mouse_left = 1'b0; cyc();
        n = 0;
        while (options_en && n < 40) begin send_tick(); n++; end
        chk("idle_restart_ticks", n, IDLE ? 20 : 40);
        diff_b = options_en; cyc(); diff_b = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) mouse_left = ~mouse_left;
            start_b   = ($urandom_range(0, 30) == 0);
            options_b = ($urandom_range(0, 25) == 0);
            diff_b    = ($urandom_range(0, 20) == 0);
            won       = ($urandom_range(0, 15) == 0);
            cards_in  = CARD_MAX_NUM_SIZE'($urandom);
            if (i % 2000 == 1999) rst = 1'b0;
            else rst = 1'b1;
            cyc();
        end
        rst = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
